pe_skew_feeder: RTL

PE_SKEW_FEEDER -- requirements
Module: pe_skew_feeder

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_skew_feeder_skew_line.sv | 28 ++
 rtl/pe_skew_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE array feeder: data/accumulator widths and
// the feeder FSM state encoding.
package pe_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } pe_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_skew_feeder_skew_line.sv
// skew_line: fixed-depth per-lane delay line, cleared asynchronously.
// Pure shift register: data moves unchanged one stage per clock.
module skew_line
  import pe_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DEPTH-1:0][DATA_W-1:0] sr;

  // shift one stage per cycle; stage 0 takes the new lane value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// pe_skew_feeder: accepts weight/activation beats and presents them to a
// systolic array with lane k delayed by k+1 cycles, then flushes the skew
// and signals fire/done. Optional beat counter: SKEW_FEEDER_BEAT_CNT_EN.
module pe_skew_feeder
  import pe_pkg::*;
#(
  parameter int rows = 16,
  parameter int cols = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [0:DATA_W*cols-1] s_w,
  input  logic [0:DATA_W*rows-1] s_a,
  output logic [0:DATA_W*cols-1] out_w_port,
  output logic [0:DATA_W*rows-1] out_a_port,
  output logic                   fire,
  output logic                   busy,
  output logic                   done
`ifdef SKEW_FEEDER_BEAT_CNT_EN
  ,
  output logic [15:0]            beat_cnt
`endif
);

  // Flush must cover the deepest lane so the last beat fully drains.
  localparam int MAXD = max_int(rows, cols);
  localparam int CW   = $clog2(MAXD + 1);

  pe_state_t state, state_nxt;
  logic [CW-1:0] fcnt, fcnt_nxt;
  logic accept, last_acc;
  logic [2:1] vld_pipe;

  logic [cols-1:0][DATA_W-1:0] w_q;
  logic [rows-1:0][DATA_W-1:0] a_q;

  assign s_ready  = (state == ST_STREAM);
  assign busy     = (state != ST_IDLE);
  assign accept   = s_valid && s_ready;
  assign last_acc = accept && s_last;

  // state and flush counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // next-state: stream until last beat, then count MAXD flush cycles
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_STREAM;
          fcnt_nxt  = '0;
        end
      end
      ST_STREAM: begin
        if (last_acc) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = '0;
        end
      end
      ST_FLUSH: begin
        if (fcnt == CW'(MAXD - 1)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          fcnt_nxt = fcnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // fire trails lane-0 data of the last beat by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1], last_acc};
  end

  assign fire = vld_pipe[2];

  // per-lane delay lines; non-accepted slots inject zero
  for (genvar k = 0; k < cols; k++) begin : g_w
    logic [DATA_W-1:0] w_in;
    assign w_in = accept ? s_w[DATA_W*k +: DATA_W] : '0;
    skew_line #(.DEPTH(k + 1)) u_w (
      .clk  (clk),
      .rstn (rstn),
      .d    (w_in),
      .q    (w_q[k])
    );
  end

  for (genvar k = 0; k < rows; k++) begin : g_a
    logic [DATA_W-1:0] a_in;
    assign a_in = accept ? s_a[DATA_W*k +: DATA_W] : '0;
    skew_line #(.DEPTH(k + 1)) u_a (
      .clk  (clk),
      .rstn (rstn),
      .d    (a_in),
      .q    (a_q[k])
    );
  end

  // map lane outputs back into the ascending-range port layout
  always_comb begin
    out_w_port = '0;
    out_a_port = '0;
    for (int k = 0; k < cols; k++) out_w_port[DATA_W*k +: DATA_W] = w_q[k];
    for (int k = 0; k < rows; k++) out_a_port[DATA_W*k +: DATA_W] = a_q[k];
  end

`ifdef SKEW_FEEDER_BEAT_CNT_EN
  // beats accepted this job; cleared on job start, saturating, held after done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               beat_cnt <= '0;
    else if (state == ST_IDLE && start)      beat_cnt <= '0;
    else if (accept && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
  end
`endif

endmodule
